wb_tlul_host_bridge: RTL and testbench

- Converts Wishbone classic slave cycles from the management SoC (wbs_* port group of the user area) into single-beat TL-UL host transactions on the Ghazi SoC crossbar.
- Sits directly downstream of the user-area Wishbone slave pins and upstream of the TL-UL crossbar host port.
- One transaction outstanding at a time.
- Has a response timeout, a source-tag check that discards stale responses, and a sticky error flag.

---
 rtl/wb_tlul_host_bridge.sv | 164 ++++++++++++++++
 tb/tb_wb_tlul_host_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_tlul_host_bridge.sv
// wb_tlul_host_bridge
// Turns Wishbone classic slave cycles into single-beat TL-UL host transactions.
// Only one transaction is outstanding at a time. A one-bit tag goes out on
// a_source and is compared on d_source, so that late responses get dropped.
// A wait for D times out after TIMEOUT cycles. err_o is a sticky flag.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wbs_*                Wishbone classic slave (cyc/stb/we/sel/adr/dat in, ack/dat out)
//   tl_a_*               TL-UL A channel (host -> crossbar)
//   tl_d_*               TL-UL D channel (crossbar -> host)
//   err_o, err_clr_i     sticky error flag and its clear
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a Wishbone strobe
// REQ   | A channel valid, holding fields until a_ready
// RSP   | waiting for a D beat with a matching source, or for the timeout
// ACK   | one-cycle Wishbone ack (suppressed if the master dropped cyc)

module wb_tlul_host_bridge #(
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned TO_W     = 16,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        tl_a_valid_o,
   input  logic        tl_a_ready_i,
   output logic [2:0]  tl_a_opcode_o,
   output logic [1:0]  tl_a_size_o,
   output logic [7:0]  tl_a_source_o,
   output logic [31:0] tl_a_address_o,
   output logic [3:0]  tl_a_mask_o,
   output logic [31:0] tl_a_data_o,
   input  logic        tl_d_valid_i,
   output logic        tl_d_ready_o,
   input  logic [7:0]  tl_d_source_i,
   input  logic [31:0] tl_d_data_i,
   input  logic        tl_d_error_i,
   output logic        err_o,
   input  logic        err_clr_i
);

   localparam logic [2:0]      OP_PUT_FULL = 3'd0;
   localparam logic [2:0]      OP_PUT_PART = 3'd1;
   localparam logic [2:0]      OP_GET      = 3'd4;
   localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, RSP, ACK} state_t;

   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q;
   logic            tag_q;
   logic            abort_q;
   logic            we_q;
   logic [2:0]      opcode_q;
   logic [3:0]      mask_q;
   logic [31:0]     address_q;
   logic [31:0]     data_q;
   logic            req_start;
   logic            rsp_hit;
   logic            rsp_timeout;

   always_comb begin
      state_d     = state_q;
      req_start   = 1'b0;
      rsp_hit     = 1'b0;
      rsp_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o) begin
               req_start = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (tl_a_ready_i) state_d = RSP;
         end
         RSP: begin
            // A matching response arriving on the timeout cycle still wins.
            if (tl_d_valid_i && (tl_d_source_i == {7'b0, tag_q})) begin
               rsp_hit = 1'b1;
               state_d = ACK;
            end else if (cnt_q == TO_LAST) begin
               rsp_timeout = 1'b1;
               state_d     = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tag_q     <= 1'b0;
         abort_q   <= 1'b0;
         we_q      <= 1'b0;
         opcode_q  <= 3'd0;
         mask_q    <= 4'd0;
         address_q <= 32'd0;
         data_q    <= 32'd0;
         wbs_dat_o <= 32'd0;
         err_o     <= 1'b0;
      end else begin
         state_q <= state_d;

         if (req_start) begin
            tag_q     <= ~tag_q;
            abort_q   <= 1'b0;
            we_q      <= wbs_we_i;
            address_q <= wbs_adr_i & 32'hFFFF_FFFC;
            data_q    <= wbs_dat_i;
            if (!wbs_we_i) begin
               opcode_q <= OP_GET;
               mask_q   <= 4'hF;
            end else begin
               opcode_q <= (wbs_sel_i == 4'hF) ? OP_PUT_FULL : OP_PUT_PART;
               mask_q   <= wbs_sel_i;
            end
         end

         // The transaction runs to completion after the master drops cyc;
         // only the ack pulse is withheld.
         if ((state_q == REQ || state_q == RSP) && !wbs_cyc_i) abort_q <= 1'b1;

         if (state_q == REQ)      cnt_q <= '0;
         else if (state_q == RSP) cnt_q <= cnt_q + TO_W'(1);

         if (rsp_hit) begin
            if (tl_d_error_i) wbs_dat_o <= ERR_DATA;
            else if (we_q)    wbs_dat_o <= 32'd0;
            else              wbs_dat_o <= tl_d_data_i;
         end else if (rsp_timeout) begin
            wbs_dat_o <= ERR_DATA;
         end

         if ((rsp_hit && tl_d_error_i) || rsp_timeout) err_o <= 1'b1;
         else if (err_clr_i)                           err_o <= 1'b0;
      end
   end

   assign wbs_ack_o      = (state_q == ACK) && !abort_q;
   assign tl_a_valid_o   = (state_q == REQ);
   assign tl_d_ready_o   = (state_q != ACK);
   assign tl_a_opcode_o  = opcode_q;
   assign tl_a_size_o    = 2'd2;
   assign tl_a_source_o  = {7'b0, tag_q};
   assign tl_a_address_o = address_q;
   assign tl_a_mask_o    = mask_q;
   assign tl_a_data_o    = data_q;

endmodule

// File: tb/tb_wb_tlul_host_bridge.sv
module tb_wb_tlul_host_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack;
   logic [31:0] rdat;
   logic        a_valid, a_ready;
   logic [2:0]  a_opcode;
   logic [1:0]  a_size;
   logic [7:0]  a_source;
   logic [31:0] a_address;
   logic [3:0]  a_mask;
   logic [31:0] a_data;
   logic        d_valid, d_ready;
   logic [7:0]  d_source;
   logic [31:0] d_data;
   logic        d_error;
   logic        err, err_clr;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   wb_tlul_host_bridge #(.TIMEOUT(8), .TO_W(16), .ERR_DATA(32'hFFFF_FFFF)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .tl_a_valid_o(a_valid), .tl_a_ready_i(a_ready), .tl_a_opcode_o(a_opcode),
      .tl_a_size_o(a_size), .tl_a_source_o(a_source), .tl_a_address_o(a_address),
      .tl_a_mask_o(a_mask), .tl_a_data_o(a_data),
      .tl_d_valid_i(d_valid), .tl_d_ready_o(d_ready), .tl_d_source_i(d_source),
      .tl_d_data_i(d_data), .tl_d_error_i(d_error),
      .err_o(err), .err_clr_i(err_clr)
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_start(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
   endtask

   task automatic wb_drop();
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic d_beat(input logic v, input logic [7:0] src, input logic [31:0] d,
                         input logic e);
      d_valid = v; d_source = src; d_data = d; d_error = e;
   endtask

   initial begin
      rst_n = 1'b0; wb_drop(); we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
      a_ready = 1'b0; d_beat(1'b0, 8'h00, 32'h0, 1'b0); err_clr = 1'b0;
      step(); step();
      check("rst_ack", ack, 0);
      check("rst_dat", rdat, 0);
      check("rst_avalid", a_valid, 0);
      check("rst_err", err, 0);
      check("rst_opcode", a_opcode, 0);
      check("rst_address", a_address, 0);
      check("rst_source", a_source, 0);
      check("rst_dready", d_ready, 1);
      rst_n = 1'b1;
      step();

      // Read at minimum latency; tag goes 0 -> 1.
      wb_start(1'b0, 32'h0000_1006, 32'h0, 4'hF); a_ready = 1'b1;
      step();
      check("rd_avalid", a_valid, 1);
      check("rd_opcode", a_opcode, 4);
      check("rd_address", a_address, 32'h0000_1004);
      check("rd_mask", a_mask, 4'hF);
      check("rd_size", a_size, 2);
      check("rd_source", a_source, 8'h01);
      d_beat(1'b1, 8'h01, 32'hCAFE_F00D, 1'b0);
      step();
      check("rd_rsp_avalid", a_valid, 0);
      check("rd_rsp_ack", ack, 0);
      step();
      check("rd_ack", ack, 1);
      check("rd_dat", rdat, 32'hCAFE_F00D);
      check("rd_ack_dready", d_ready, 0);
      wb_drop(); d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      step();
      check("rd_ack_one_cycle", ack, 0);
      check("rd_dat_hold", rdat, 32'hCAFE_F00D);

      // Full write (tag 0) then partial write (tag 1).
      wb_start(1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF);
      step();
      check("wf_opcode", a_opcode, 0);
      check("wf_mask", a_mask, 4'hF);
      check("wf_data", a_data, 32'h1234_5678);
      check("wf_source", a_source, 8'h00);
      d_beat(1'b1, 8'h00, 32'hDEAD_BEEF, 1'b0);
      step(); step();
      check("wf_ack", ack, 1);
      check("wf_dat", rdat, 0);
      wb_drop(); d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      step();
      wb_start(1'b1, 32'h0000_2005, 32'hAABB_CCDD, 4'h3);
      step();
      check("wp_opcode", a_opcode, 1);
      check("wp_mask", a_mask, 4'h3);
      check("wp_address", a_address, 32'h0000_2004);
      check("wp_source", a_source, 8'h01);
      d_beat(1'b1, 8'h01, 32'h0, 1'b0);
      step(); step();
      check("wp_ack", ack, 1);
      check("wp_dat", rdat, 0);
      wb_drop(); d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      step();

      // a_ready low for 10 cycles: no timeout in REQ, fields stable (tag 0).
      a_ready = 1'b0;
      wb_start(1'b0, 32'h0000_3000, 32'h0, 4'hF);
      step();
      for (int i = 0; i < 10; i++) begin
         check("stall_avalid", a_valid, 1);
         check("stall_address", a_address, 32'h0000_3000);
         check("stall_opcode", a_opcode, 4);
         check("stall_ack", ack, 0);
         step();
      end
      check("stall_still_req", a_valid, 1);
      a_ready = 1'b1;
      d_beat(1'b1, 8'h00, 32'h1111_2222, 1'b0);
      step();
      check("stall_handshake", a_valid, 0);
      step();
      check("stall_ack", ack, 1);
      check("stall_dat", rdat, 32'h1111_2222);
      wb_drop(); d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      step();

      // Timeout with no response (tag 1): 8 RSP cycles, then ack.
      wb_start(1'b0, 32'h0000_4000, 32'h0, 4'hF);
      step();
      step();
      check("to_rsp_entry", a_valid, 0);
      for (int i = 0; i < 7; i++) begin
         step();
         check("to_wait_ack", ack, 0);
      end
      step();
      check("to_ack", ack, 1);
      check("to_dat", rdat, 32'hFFFF_FFFF);
      check("to_err", err, 1);
      wb_drop();
      step();

      // Stale response with old tag 1 during the next read (tag 0) is discarded.
      wb_start(1'b0, 32'h0000_5000, 32'h0, 4'hF);
      step();
      check("stale_source", a_source, 8'h00);
      d_beat(1'b1, 8'h01, 32'hBAD0_BAD0, 1'b0);
      step();
      step();
      check("stale_no_ack", ack, 0);
      d_beat(1'b1, 8'h00, 32'h5555_6666, 1'b0);
      step();
      check("stale_ack", ack, 1);
      check("stale_dat", rdat, 32'h5555_6666);
      check("stale_err_sticky", err, 1);
      wb_drop(); d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("clr_after_to", err, 0);

      // d_error on a read (tag 1).
      wb_start(1'b0, 32'h0000_6000, 32'h0, 4'hF);
      step();
      d_beat(1'b1, 8'h01, 32'h0000_0000, 1'b1);
      step(); step();
      check("derr_ack", ack, 1);
      check("derr_dat", rdat, 32'hFFFF_FFFF);
      check("derr_err", err, 1);
      wb_drop(); d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("derr_clr", err, 0);

      // Set and clear in the same cycle (tag 0): set wins.
      wb_start(1'b0, 32'h0000_6004, 32'h0, 4'hF);
      step();
      d_beat(1'b1, 8'h00, 32'h0, 1'b1);
      err_clr = 1'b1;
      step(); step();
      check("setclr_ack", ack, 1);
      check("setclr_err", err, 1);
      wb_drop(); d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      err_clr = 1'b0;
      step();

      // Abort: cyc dropped in RSP (tag 1); ACK passes with no pulse.
      wb_start(1'b0, 32'h0000_7000, 32'h0, 4'hF);
      step(); step();
      wb_drop();
      d_beat(1'b1, 8'h01, 32'h7777_8888, 1'b0);
      step();
      check("abort_no_ack", ack, 0);
      check("abort_in_ack_state", d_ready, 0);
      d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      step();
      check("abort_idle_ack", ack, 0);
      check("abort_idle_dready", d_ready, 1);
      wb_start(1'b0, 32'h0000_7004, 32'h0, 4'hF);
      step();
      check("post_abort_source", a_source, 8'h00);
      d_beat(1'b1, 8'h00, 32'h9999_AAAA, 1'b0);
      step(); step();
      check("post_abort_ack", ack, 1);
      check("post_abort_dat", rdat, 32'h9999_AAAA);
      wb_drop(); d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      step();

      // Reset asserted while in REQ (tag 1); err is still set from above.
      a_ready = 1'b0;
      wb_start(1'b1, 32'h0000_8000, 32'h0BAD_CAFE, 4'h5);
      step();
      check("mid_rst_req", a_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_avalid", a_valid, 0);
      check("mid_rst_ack", ack, 0);
      check("mid_rst_dat", rdat, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_opcode", a_opcode, 0);
      check("mid_rst_mask", a_mask, 0);
      check("mid_rst_address", a_address, 0);
      check("mid_rst_data", a_data, 0);
      check("mid_rst_source", a_source, 0);
      wb_drop();
      step();
      rst_n = 1'b1;
      a_ready = 1'b1;
      step();
      wb_start(1'b0, 32'h0000_9000, 32'h0, 4'hF);
      step();
      check("after_rst_source", a_source, 8'h01);
      d_beat(1'b1, 8'h01, 32'h0F0F_1234, 1'b0);
      step(); step();
      check("after_rst_ack", ack, 1);
      check("after_rst_dat", rdat, 32'h0F0F_1234);
      wb_drop(); d_beat(1'b0, 8'h00, 32'h0, 1'b0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
